// File: rtl/m31_mul_scheduler_if.sv
// Bus bundle between the M31 multiplier scheduler, its requesters and the shared multiplier.
// The slave modport is the scheduler's view; master is the environment's view.
interface m31_mul_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 31
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [DATA_WIDTH-1:0]         mul_a;
  logic [DATA_WIDTH-1:0]         mul_b;
  logic                          mul_issue;
  logic [DATA_WIDTH-1:0]         mul_result;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport slave (
    input  req_valid, req_a, req_b, mul_result,
    output req_ready, mul_a, mul_b, mul_issue, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_a, req_b, mul_result,
    input  req_ready, mul_a, mul_b, mul_issue, resp_valid, resp_data
  );
endinterface

// File: rtl/m31_mul_scheduler.sv
// Round-robin scheduler sharing one M31 multiplier among NUM_REQ requesters.
// A tag pipeline matched to the multiplier latency routes each result back to its owner.
module m31_mul_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 0,
  parameter int DATA_WIDTH  = 31
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      busy,
  m31_mul_scheduler_if.slave        bus
);

  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int TAG_IDX_W = (MUL_LATENCY + 1) * IDX_W;

  logic [IDX_W-1:0]                   last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0]              mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0]              mul_b_q, mul_b_d;
  logic [DATA_WIDTH-1:0]              resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]                 resp_valid_q, resp_valid_d;
  logic [MUL_LATENCY:0]               tag_valid_q, tag_valid_d;
  logic [MUL_LATENCY:0][IDX_W-1:0]    tag_idx_q, tag_idx_d;

  logic [NUM_REQ-1:0]                 grant;
  logic [IDX_W-1:0]                   grant_idx;
  logic                               accept;
  logic [DATA_WIDTH-1:0]              sel_a, sel_b;

  // Search starts one past the last winner and wraps; reset and enable gate every grant.
  always_comb begin
    int              cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant     = '0;
    grant_idx = last_grant_q;
    accept    = 1'b0;
    if (rst_n && enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(last_grant_q) + 1 + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!accept && bus.req_valid[cand_idx]) begin
          accept    = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
    if (accept) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Operands only move on acceptance; the tag stage at MUL_LATENCY lines up with mul_result.
  always_comb begin
    last_grant_d = last_grant_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    if (accept) begin
      last_grant_d = grant_idx;
      mul_a_d      = sel_a;
      mul_b_d      = sel_b;
    end

    tag_valid_d = (MUL_LATENCY + 1)'({tag_valid_q, accept});
    tag_idx_d   = TAG_IDX_W'({tag_idx_q, grant_idx});

    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_valid_q[MUL_LATENCY]) begin
      resp_valid_d[tag_idx_q[MUL_LATENCY]] = 1'b1;
      resp_data_d                          = bus.mul_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
      tag_valid_q  <= '0;
      tag_idx_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      tag_valid_q  <= tag_valid_d;
      tag_idx_q    <= tag_idx_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_issue  = tag_valid_q[0];
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = |tag_valid_q;

endmodule

// File: tb/tb_m31_mul_scheduler.sv
// Drives two schedulers (multiplier latency 0 and 2) with identical stimulus and
// compares them against a history-table model of grants, operands, responses and busy.
module tb_m31_mul_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 31;
  localparam int MAXC = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic            busy0, busy2;
  logic [DW-1:0]   pipe1, pipe2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: per-cycle acceptance history, cleared logically by moving floorC.
  bit            hv   [MAXC];
  int            hidx [MAXC];
  logic [DW-1:0] ha   [MAXC];
  logic [DW-1:0] hb   [MAXC];
  logic [DW-1:0] hp   [MAXC];
  int            floorC = 0;
  int            mlast  = NR - 1;

  m31_mul_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if0 ();
  m31_mul_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) if2 ();

  function automatic logic [DW-1:0] m31mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] p;
    p = {33'd0, a} * {33'd0, b};
    return DW'(p % 64'd2147483647);
  endfunction

  assign if0.req_valid  = req_valid;
  assign if0.req_a      = req_a;
  assign if0.req_b      = req_b;
  assign if0.mul_result = m31mul(if0.mul_a, if0.mul_b);

  assign if2.req_valid  = req_valid;
  assign if2.req_a      = req_a;
  assign if2.req_b      = req_b;
  assign if2.mul_result = pipe2;

  always @(posedge clk) begin
    pipe1 <= m31mul(if2.mul_a, if2.mul_b);
    pipe2 <= pipe1;
  end

  m31_mul_scheduler #(.NUM_REQ(NR), .MUL_LATENCY(0), .DATA_WIDTH(DW)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy0), .bus(if0)
  );

  m31_mul_scheduler #(.NUM_REQ(NR), .MUL_LATENCY(2), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .busy(busy2), .bus(if2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [NR-1:0] v,
                               input logic [NR*DW-1:0] a, input logic [NR*DW-1:0] b);
    @(posedge clk);
    #1;
    rst_n     = rst;
    enable    = en;
    req_valid = v;
    req_a     = a;
    req_b     = b;
  endtask

  function automatic logic [NR*DW-1:0] slotVal(input int i, input logic [DW-1:0] x);
    logic [NR*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] randOps();
    logic [NR*DW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic bit accAt(input int c);
    if (c < floorC || c < 0 || c >= MAXC) return 1'b0;
    return hv[c];
  endfunction

  function automatic int lastAcc(input int c);
    for (int d = c; d >= floorC && d >= 0; d--) begin
      if (hv[d]) return d;
    end
    return -1;
  endfunction

  task automatic modelCheckLat(input int lat, input string tag, input logic [NR-1:0] rv,
                               input logic [DW-1:0] rd, input logic bz);
    logic [NR-1:0] erv;
    logic [DW-1:0] erd;
    logic          ebz;
    int            d;
    erv = '0;
    if (accAt(cyc - 2 - lat)) erv[hidx[cyc - 2 - lat]] = 1'b1;
    d   = lastAcc(cyc - 2 - lat);
    erd = (d >= 0) ? hp[d] : '0;
    ebz = 1'b0;
    for (int k = cyc - 1 - lat; k <= cyc - 1; k++) if (accAt(k)) ebz = 1'b1;
    checkOutput({tag, "_resp_valid"}, 32'(rv), 32'(erv));
    checkOutput({tag, "_resp_data"},  32'(rd), 32'(erd));
    checkOutput({tag, "_busy"},       32'(bz), 32'(ebz));
  endtask

  // Reference model: evaluated mid-cycle from the inputs currently applied.
  always @(negedge clk) begin
    logic [NR-1:0] eready;
    logic [DW-1:0] ea, eb;
    int gi, idx, d;
    if (cyc >= MAXC) begin
      $display("[TB] FAIL model_capacity actual=%0d expected=<%0d", cyc, MAXC);
      $fatal(1, "[TB] history overflow");
    end
    if (!rst_n) begin
      floorC = cyc + 1;
      mlast  = NR - 1;
    end
    modelCheckLat(0, "L0", if0.resp_valid, if0.resp_data, busy0);
    modelCheckLat(2, "L2", if2.resp_valid, if2.resp_data, busy2);

    d  = lastAcc(cyc - 1);
    ea = (d >= 0) ? ha[d] : '0;
    eb = (d >= 0) ? hb[d] : '0;
    checkOutput("L0_mul_issue", 32'(if0.mul_issue), 32'(accAt(cyc - 1)));
    checkOutput("L2_mul_issue", 32'(if2.mul_issue), 32'(accAt(cyc - 1)));
    checkOutput("L0_mul_a", 32'(if0.mul_a), 32'(ea));
    checkOutput("L0_mul_b", 32'(if0.mul_b), 32'(eb));
    checkOutput("L2_mul_a", 32'(if2.mul_a), 32'(ea));
    checkOutput("L2_mul_b", 32'(if2.mul_b), 32'(eb));

    eready = '0;
    gi     = -1;
    if (rst_n && enable) begin
      for (int k = 0; k < NR; k++) begin
        idx = (mlast + 1 + k) % NR;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) eready[gi] = 1'b1;
    checkOutput("L0_req_ready", 32'(if0.req_ready), 32'(eready));
    checkOutput("L2_req_ready", 32'(if2.req_ready), 32'(eready));

    hv[cyc] = (gi >= 0);
    if (gi >= 0) begin
      hidx[cyc] = gi;
      ha[cyc]   = req_a[gi*DW +: DW];
      hb[cyc]   = req_b[gi*DW +: DW];
      hp[cyc]   = m31mul(req_a[gi*DW +: DW], req_b[gi*DW +: DW]);
      mlast     = gi;
    end
  end

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b1, '0, '0, '0);
  endtask

  // One request from requester 0, then hand-derived response timing for both latencies.
  task automatic runSingle(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] exp);
    applyStimulus(1'b1, 1'b1, 4'b0001, slotVal(0, a), slotVal(0, b));
    @(negedge clk);
    checkOutput({name, "_grant"}, 32'(if0.req_ready), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, '0, '0, '0);
      @(negedge clk);
      checkOutput($sformatf("%s_L0_rv_k%0d", name, k), 32'(if0.resp_valid), (k == 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("%s_L2_rv_k%0d", name, k), 32'(if2.resp_valid), (k == 4) ? 32'h1 : 32'h0);
      checkOutput($sformatf("%s_L0_busy_k%0d", name, k), 32'(busy0), (k < 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("%s_L2_busy_k%0d", name, k), 32'(busy2), (k < 4) ? 32'h1 : 32'h0);
      if (k == 2) checkOutput({name, "_L0_data"}, 32'(if0.resp_data), 32'(exp));
      if (k == 4) checkOutput({name, "_L2_data"}, 32'(if2.resp_data), 32'(exp));
    end
  endtask

  typedef struct {
    logic          en;
    logic [NR-1:0] valid;
    logic [NR-1:0] ready;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 4'b0001, 4'b0001};
    vecs[1] = '{1'b1, 4'b0001, 4'b0001};
    vecs[2] = '{1'b1, 4'b1111, 4'b0010};
    vecs[3] = '{1'b0, 4'b1111, 4'b0000};
    vecs[4] = '{1'b1, 4'b0000, 4'b0000};
    vecs[5] = '{1'b1, 4'b1001, 4'b1000};
    vecs[6] = '{1'b1, 4'b1001, 4'b0001};
    vecs[7] = '{1'b1, 4'b0110, 4'b0010};
    vecs[8] = '{1'b1, 4'b0100, 4'b0100};
    vecs[9] = '{1'b1, 4'b0011, 4'b0001};

    $display("[TB] start");
    resetDut();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].en, vecs[i].valid, randOps(), randOps());
      @(negedge clk);
      checkOutput($sformatf("vec%0d_L0_ready", i), 32'(if0.req_ready), 32'(vecs[i].ready));
      checkOutput($sformatf("vec%0d_L2_ready", i), 32'(if2.req_ready), 32'(vecs[i].ready));
    end
    idle(6);

    runSingle("single", 31'd2, 31'd3, 31'd6);
    runSingle("wrap_pm1", 31'h7FFFFFFE, 31'h7FFFFFFE, 31'd1);
    runSingle("wrap_2p16", 31'h00010000, 31'h00010000, 31'd2);

    // All four requesters held valid: grants must rotate 0,1,2,3,...
    resetDut();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 4'b1111, randOps(), randOps());
      @(negedge clk);
      checkOutput($sformatf("fair_L0_k%0d", k), 32'(if0.req_ready), 32'(1 << (k % 4)));
      checkOutput($sformatf("fair_L2_k%0d", k), 32'(if2.req_ready), 32'(1 << (k % 4)));
    end
    idle(6);

    // Two ops in flight, then enable drops: both responses still arrive, no grants.
    resetDut();
    applyStimulus(1'b1, 1'b1, 4'b1111, randOps(), randOps());
    applyStimulus(1'b1, 1'b1, 4'b1111, randOps(), randOps());
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b1111, randOps(), randOps());
      @(negedge clk);
      checkOutput($sformatf("gate_ready_k%0d", k), 32'(if0.req_ready), 32'h0);
      checkOutput($sformatf("gate_L0_rv_k%0d", k), 32'(if0.resp_valid),
                  (k == 0) ? 32'h1 : (k == 1) ? 32'h2 : 32'h0);
      checkOutput($sformatf("gate_L2_rv_k%0d", k), 32'(if2.resp_valid),
                  (k == 2) ? 32'h1 : (k == 3) ? 32'h2 : 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 4'b1111, randOps(), randOps());
    @(negedge clk);
    checkOutput("gate_resume", 32'(if0.req_ready), 32'h4);
    idle(6);

    // Reset one cycle after an acceptance: everything clears at once, nothing responds later.
    resetDut();
    applyStimulus(1'b1, 1'b1, 4'b0001, slotVal(0, 31'd5), slotVal(0, 31'd7));
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_L0_issue", 32'(if0.mul_issue), 32'h0);
    checkOutput("rst_L0_mul_a", 32'(if0.mul_a), 32'h0);
    checkOutput("rst_L0_mul_b", 32'(if0.mul_b), 32'h0);
    checkOutput("rst_L0_busy",  32'(busy0), 32'h0);
    checkOutput("rst_L0_ready", 32'(if0.req_ready), 32'h0);
    checkOutput("rst_L0_data",  32'(if0.resp_data), 32'h0);
    checkOutput("rst_L2_busy",  32'(busy2), 32'h0);
    checkOutput("rst_L2_rv",    32'(if2.resp_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, '0, '0, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_L0_norsp_k%0d", k), 32'(if0.resp_valid), 32'h0);
      checkOutput($sformatf("rst_L2_norsp_k%0d", k), 32'(if2.resp_valid), 32'h0);
      applyStimulus(1'b1, 1'b1, '0, '0, '0);
    end
    applyStimulus(1'b1, 1'b1, 4'b1111, randOps(), randOps());
    @(negedge clk);
    checkOutput("rst_first_grant", 32'(if0.req_ready), 32'h1);
    idle(6);

    // Random traffic with occasional resets and enable drops.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom % 60) != 0, ($urandom % 6) != 0, NR'($urandom), randOps(), randOps());
    end
    idle(8);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
